// File: rtl/tc_spi_frame_master.sv
// tc_spi_frame_master: mode-0, MSB-first SPI frame engine fed by a valid/ready command port.
// Define TC_SPI_RDBK_EN to build the SDO receive path; otherwise rx_data is tied to zero.
module tc_spi_frame_master #(
  parameter int unsigned FRAME_W = 24,
  parameter int unsigned DIV     = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic               clk125,
  input  logic               rst,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               busy,
  output logic               spi_csn,
  output logic               spi_sck,
  output logic               spi_sdi,
  input  logic               spi_sdo
);

  localparam int unsigned BIT_W = $clog2(FRAME_W + 1);
  localparam int unsigned DIV_W = $clog2(DIV + 1);
  localparam int unsigned GAP_W = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_H, SHIFT_L, GAP} state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] tx_sr;
  logic               accept;
  logic               div_done;
  logic               gap_done;
  logic               sck_fall;
  logic               frame_end;

  assign accept    = tx_valid & tx_ready;
  assign div_done  = (div_cnt == DIV_W'(DIV - 1));
  assign gap_done  = (gap_cnt == GAP_W'(CS_GAP - 1));
  assign sck_fall  = (state == SHIFT_H) && (state_nx == SHIFT_L);
  assign frame_end = (state == SHIFT_L) && (state_nx == GAP);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)   state_nx = SETUP;
      SETUP:   if (div_done) state_nx = SHIFT_H;
      SHIFT_H: if (div_done) state_nx = SHIFT_L;
      SHIFT_L: if (div_done) state_nx = (bit_cnt != '0) ? SHIFT_H : GAP;
      GAP:     if (gap_done) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk125) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      spi_csn  <= 1'b1;
      spi_sck  <= 1'b0;
      spi_sdi  <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b1;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      spi_csn  <= !(state_nx inside {SETUP, SHIFT_H, SHIFT_L});
      spi_sck  <= (state_nx == SHIFT_H);
      tx_ready <= (state_nx == IDLE);
      busy     <= (state_nx != IDLE);
      rx_valid <= frame_end;

      if (state_nx != state) begin
        div_cnt <= '0;
      end else if (state inside {SETUP, SHIFT_H, SHIFT_L}) begin
        div_cnt <= div_cnt + 1'b1;
      end

      if ((state == GAP) && (state_nx == GAP)) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end

      // bit_cnt holds the bits not yet clocked out, including the one on SDI.
      if (accept) begin
        tx_sr   <= tx_data;
        bit_cnt <= BIT_W'(FRAME_W);
        spi_sdi <= tx_data[FRAME_W-1];
      end else if (sck_fall) begin
        bit_cnt <= bit_cnt - 1'b1;
        if (bit_cnt > BIT_W'(1)) begin
          tx_sr   <= {tx_sr[FRAME_W-2:0], 1'b0};
          spi_sdi <= tx_sr[FRAME_W-2];
        end
      end else if (state_nx == GAP) begin
        spi_sdi <= 1'b0;
      end
    end
  end

`ifdef TC_SPI_RDBK_EN
  logic [FRAME_W-1:0] rx_sr;

  always_ff @(posedge clk125) begin
    if (rst) begin
      rx_sr   <= '0;
      rx_data <= '0;
    end else begin
      if ((state != SHIFT_H) && (state_nx == SHIFT_H)) begin
        rx_sr <= {rx_sr[FRAME_W-2:0], spi_sdo};
      end
      if (frame_end) begin
        rx_data <= rx_sr;
      end
    end
  end
`else
  logic unused_sdo;

  assign unused_sdo = spi_sdo;
  assign rx_data    = '0;
`endif

endmodule

// File: tb/tb_tc_spi_frame_master.sv
// Scoreboard bench for tc_spi_frame_master: default-parameter instance plus a minimum-parameter one.
module tb_tc_spi_frame_master;

`ifdef TC_SPI_RDBK_EN
  localparam bit RDBK = 1'b1;
`else
  localparam bit RDBK = 1'b0;
`endif
  localparam int DIV_A = 4;
  localparam int GAP_A = 4;

  typedef struct {
    logic [23:0] tx;
    logic [23:0] rx;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [23:0] a_data = 24'hA5F00F;
  logic        a_valid = 1'b1;
  logic        a_ready, a_rxv, a_busy, a_csn, a_sck, a_sdi;
  logic [23:0] a_rxd;
  logic        sdo_a = 1'b0;
  logic [23:0] resp_a = 24'h3C5A96;

  logic [1:0]  b_data = 2'b00;
  logic        b_valid = 1'b0;
  logic        b_ready, b_rxv, b_busy, b_csn, b_sck, b_sdi;
  logic [1:0]  b_rxd;
  logic        sdo_b = 1'b0;
  logic [1:0]  resp_b = 2'b01;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int a_rises  = 0;
  exp_t        q_a[$];
  logic [1:0]  q_b[$];

  always #5 clk = ~clk;

  tc_spi_frame_master #(.FRAME_W(24), .DIV(DIV_A), .CS_GAP(GAP_A)) u_a (
    .clk125(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .rx_data(a_rxd), .rx_valid(a_rxv), .busy(a_busy), .spi_csn(a_csn), .spi_sck(a_sck),
    .spi_sdi(a_sdi), .spi_sdo(sdo_a)
  );

  tc_spi_frame_master #(.FRAME_W(2), .DIV(1), .CS_GAP(1)) u_b (
    .clk125(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .rx_data(b_rxd), .rx_valid(b_rxv), .busy(b_busy), .spi_csn(b_csn), .spi_sck(b_sck),
    .spi_sdi(b_sdi), .spi_sdo(sdo_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_rx(input logic [23:0] r);
    return RDBK ? r : 24'h0;
  endfunction

  // Device models: present MSB when CSN falls, next bit after each SCK fall (mode 0).
  initial begin
    int          idx_a, idx_b;
    logic [23:0] word_a;
    logic [1:0]  word_b;
    logic        pc_a, ps_a, pc_b, ps_b;
    idx_a = 0; idx_b = 0; word_a = '0; word_b = '0;
    pc_a = 1'b1; ps_a = 1'b0; pc_b = 1'b1; ps_b = 1'b0;
    forever begin
      @(negedge clk);
      if (RDBK) begin
        if (!a_csn && pc_a) begin
          idx_a = 23; word_a = resp_a; sdo_a = word_a[23];
        end else if (!a_sck && ps_a && idx_a > 0) begin
          idx_a--; sdo_a = word_a[idx_a];
        end
      end else begin
        sdo_a = 1'($urandom_range(0, 1));
      end
      if (!b_csn && pc_b) begin
        idx_b = 1; word_b = resp_b; sdo_b = word_b[1];
      end else if (!b_sck && ps_b && idx_b > 0) begin
        idx_b--; sdo_b = word_b[idx_b];
      end
      pc_a = a_csn; ps_a = a_sck; pc_b = b_csn; ps_b = b_sck;
    end
  end

  // Monitor for the default instance: tracks each frame and pops the scoreboard on rx_valid.
  initial begin
    int          cyc, lo_cnt, hi_cnt, last_gap, last_rise, space_err;
    logic [23:0] cap;
    logic        p_csn, p_sck, p_rxv;
    exp_t        e;
    cyc = 0; lo_cnt = 0; hi_cnt = 0; last_gap = -1; last_rise = 0; space_err = 0;
    cap = '0; p_csn = 1'b1; p_sck = 1'b0; p_rxv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        lo_cnt = 0; hi_cnt = 0; last_gap = -1; a_rises = 0; space_err = 0; cap = '0;
        p_csn = 1'b1; p_sck = 1'b0; p_rxv = 1'b0;
      end else begin
        if (p_rxv) check("rx_valid_width", a_rxv, 0);
        if (!a_csn && p_csn) begin
          last_gap = hi_cnt; hi_cnt = 0; lo_cnt = 0; a_rises = 0; cap = '0; space_err = 0;
        end
        if (!a_csn) lo_cnt++; else hi_cnt++;
        if (a_sck && !p_sck) begin
          if (a_rises > 0 && (cyc - last_rise) != 2 * DIV_A) space_err++;
          last_rise = cyc;
          a_rises++;
          cap = {cap[22:0], a_sdi};
        end
        if (a_rxv) begin
          pulses_a++;
          if (q_a.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_rx_valid: got rx_valid=1 with no frame pending, expected 0 at %0t", $time);
          end else begin
            e = q_a.pop_front();
            check("csn_high_at_rx_valid", a_csn, 1);
            check("csn_low_cycles", lo_cnt, 196);
            check("sck_rises", a_rises, 24);
            check("sck_spacing_errors", space_err, 0);
            check("sdi_frame", cap, e.tx);
            check("rx_data", a_rxd, e.rx);
            if (e.gap >= 0) check("csn_gap_cycles", last_gap, e.gap);
          end
        end
        p_csn = a_csn; p_sck = a_sck; p_rxv = a_rxv;
      end
    end
  end

  // Monitor for the minimum-parameter instance.
  initial begin
    logic [1:0] eb;
    forever begin
      @(negedge clk);
      if (!rst && b_rxv) begin
        pulses_b++;
        if (q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rx_valid_b: got rx_valid=1 with no frame pending, expected 0 at %0t", $time);
        end else begin
          eb = q_b.pop_front();
          check("b_rx_data", b_rxd, eb);
          check("b_csn_high_at_rx_valid", b_csn, 1);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_a(input logic [23:0] d, input logic [23:0] r, input int gap,
                        input bit hold, input bit track);
    int t;
    t = 0;
    while (!a_ready && t < 2000) begin @(negedge clk); t++; end
    if (!a_ready) check("ready_timeout", 0, 1);
    a_data = d; a_valid = 1'b1; resp_a = r;
    if (track) q_a.push_back('{tx: d, rx: exp_rx(r), gap: gap});
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      a_valid = 1'b0;
      a_data  = ~d;
    end
  endtask

  // The accept cycle is cycle 0; the negedge on entry is cycle 1.
  task automatic measure_ready_a(input int exp);
    int c;
    c = 1;
    while (!a_ready && c < 2000) begin @(negedge clk); c++; end
    check("accept_to_ready", c, exp);
  endtask

  initial begin
    logic [2:0] vec_b [6];
    int         t, c;
    vec_b = '{3'b001, 3'b011, 3'b000, 3'b010, 3'b000, 3'b100};

    // Reset, with tx_valid already asserted.
    repeat (3) @(negedge clk);
    check("rst_csn", a_csn, 1);
    check("rst_sck", a_sck, 0);
    check("rst_sdi", a_sdi, 0);
    check("rst_tx_ready", a_ready, 0);
    check("rst_busy", a_busy, 1);
    check("rst_rx_valid", a_rxv, 0);
    check("rst_rx_data", a_rxd, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", a_ready, 1);
    check("valid_in_reset_ignored", a_csn, 1);
    check("busy_after_release", a_busy, 0);

    send_a(24'hA5F00F, 24'h3C5A96, -1, 1'b0, 1'b1);
    check("busy_after_accept", a_busy, 1);
    measure_ready_a(201);
    repeat (5) @(negedge clk);
    check("rx_hold", a_rxd, exp_rx(24'h3C5A96));

    // Back-to-back with tx_valid held: CS_GAP cycles of GAP plus the accept cycle in IDLE.
    send_a(24'h000001, 24'h123456, -1, 1'b1, 1'b1);
    send_a(24'h800000, 24'hFEDCBA, GAP_A + 1, 1'b0, 1'b1);
    measure_ready_a(201);

    // Mid-frame reset at bit 10.
    send_a(24'h5A5A5A, 24'hFFFFFF, -1, 1'b0, 1'b0);
    t = 0;
    while (a_rises < 10 && t < 2000) begin @(negedge clk); t++; end
    check("bit10_reached", (a_rises >= 10), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_csn", a_csn, 1);
    check("abort_sck", a_sck, 0);
    check("abort_rx_valid", a_rxv, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("no_pulse_after_abort", pulses_a, 3);
    send_a(24'h0F0F0F, 24'hC33C55, -1, 1'b0, 1'b1);
    measure_ready_a(201);
    repeat (3) @(negedge clk);
    check("rx_hold_post_reset", a_rxd, exp_rx(24'hC33C55));

    // Minimum parameters: DIV=1, CS_GAP=1, FRAME_W=2.
    t = 0;
    while (!b_ready && t < 100) begin @(negedge clk); t++; end
    check("b_ready", b_ready, 1);
    b_data = 2'b10; b_valid = 1'b1; resp_b = 2'b01;
    q_b.push_back(RDBK ? 2'b01 : 2'b00);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0; b_data = 2'b01;
    check("b_busy", b_busy, 1);
    c = 1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b_pins_cycle%0d", i + 1), {b_csn, b_sck, b_sdi}, vec_b[i]);
      @(negedge clk);
      c++;
    end
    while (!b_ready && c < 100) begin @(negedge clk); c++; end
    check("b_accept_to_ready", c, 7);

    repeat (5) @(negedge clk);
    check("q_a_empty", q_a.size(), 0);
    check("q_b_empty", q_b.size(), 0);
    check("pulses_a", pulses_a, 4);
    check("pulses_b", pulses_b, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
